pipe_trace_monitor: RTL
=======================

Name: pipe_trace_monitor

Overview:
Synthesizable N-lane pipeline observation block for the multi-issue RV32I core. Each cycle it samples per-lane execute-stage taps, maintains cycle, retire, stall and bubble counters, and packs one trace record into an internal FIFO for an off-chip or bench drain port. It detects ECALL/EBREAK and a programmable cycle watchdog, then drains outstanding trace records and reports done with a halt cause. It replaces bench-only halt/trace logic so the same monitoring works on FPGA builds.

Parameters:
LANES, 2, number of execute lanes observed (1..4)
XLEN, 32, instruction/result width
CNT_W, 32, width of all counters and of max_cycles
TRACE_DEPTH, 16, trace FIFO entries (power of two, >=2)

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
lane_valid  in  LANES  lane k holds a real (non-bubble) instruction in execute this cycle
lane_instr  in  LANES*XLEN  execute-stage instruction per lane, lane k at bits [k*XLEN +: XLEN]
lane_result  in  LANES*XLEN  execute-stage result per lane
stall  in  1  pipeline stall this cycle
branch_taken  in  1  branch/jump redirect this cycle
max_cycles  in  CNT_W  watchdog limit; 0 disables the watchdog
trace_valid  out  1  trace_data holds a record
trace_ready  in  1  consumer accepts the record when trace_valid && trace_ready
trace_data  out  CNT_W+2+LANES+2*LANES*XLEN  record = {cycle, stall, branch_taken, lane_valid, instrs, results}
cycle_count  out  CNT_W  cycles spent in RUN
retired_count  out  CNT_W  sum of set lane_valid bits during RUN
stall_count  out  CNT_W  RUN cycles with stall=1
drop_count  out  CNT_W  records lost to a full FIFO
halted  out  1  halt detected (sticky)
halt_cause  out  2  0 none, 1 ECALL, 2 EBREAK, 3 watchdog
halt_lane  out  2  lowest lane index holding the system instruction
done  out  1  halted and FIFO drained (sticky)

Behaviour:
- Reset (any time, mid-run included): all counters 0, FIFO empty, trace_valid=0, halted=0, halt_cause=0, halt_lane=0, done=0, state RUN on the first edge after deassertion.
- States: RUN -> DRAIN on halt detection; DRAIN -> DONE when FIFO empty; DONE is terminal until reset.
- RUN, every cycle: cycle_count+1; retired_count += popcount(lane_valid); stall_count+1 if stall; a record is built with cycle = current cycle_count (pre-increment) and pushed.
- Counters saturate at all-ones and never wrap.
- Halt detection in RUN: any lane with lane_valid=1 and instr 0x00000073 gives ECALL; 0x00100073 gives EBREAK; lowest lane index wins. If neither and max_cycles!=0 and cycle_count+1 >= max_cycles, the cause is watchdog (cause 3, halt_lane=0). A system instruction takes priority over the watchdog in the same cycle.
- The halting cycle is itself counted and recorded. halted/halt_cause/halt_lane become visible on the following edge (1-cycle latency). No counting or pushing occurs in DRAIN or DONE.
- FIFO is first-word-fall-through: a record pushed at edge N is on trace_data after edge N. Push while full drops the new record and increments drop_count. Pop and push in the same cycle when full is allowed and succeeds (pop frees the slot). trace_data is held stable while trace_valid && !trace_ready.
- done asserts the edge after the FIFO becomes empty in DRAIN; if the FIFO is already empty at halt, done asserts one cycle after halted.

Optional Feature:
PIPE_MON_FILTER_EN: when defined, RUN cycles with lane_valid==0 and stall==0 push no record (counters still update, no drop counted). The halting cycle is always recorded. Without the macro, every RUN cycle pushes a record.

Decomposition:
- The shared package (rv32i_pkg) holds the constants INSTR_ECALL=32'h00000073 and INSTR_EBREAK=32'h00100073, and the halt_cause_e enum {HALT_NONE, HALT_ECALL, HALT_EBREAK, HALT_WDOG}.
- One sub-module, mon_fifo: parametrised width/depth FWFT FIFO with full/empty and simultaneous push/pop.

Test Plan:
- LANES=2; 5 cycles lane_valid=2'b11 with NOPs, trace_ready=1 -> retired_count=10, cycle_count=5, 5 records with cycle fields 0..4.
- Lane1 instr 0x00100073 valid at cycle 7 while lane0 is a NOP -> halted=1 at cycle 8, halt_cause=2, halt_lane=1, done once 8 records are drained.
- Both lanes ECALL in the same cycle as watchdog expiry -> halt_cause=1, halt_lane=0.
- max_cycles=20, no system instruction, trace_ready=1 -> halt_cause=3, cycle_count=20, done.
- trace_ready=0 for 30 RUN cycles, TRACE_DEPTH=16 -> drop_count=14; first record (cycle 0) is held stable, then drains in order on ready.
- Assert rst mid-RUN with 5 records queued -> all outputs zero immediately; with PIPE_MON_FILTER_EN, 4 idle cycles push 0 records.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I system-instruction constants, halt causes and monitor states
package rv32i_pkg;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        HALT_NONE   = 2'd0,
        HALT_ECALL  = 2'd1,
        HALT_EBREAK = 2'd2,
        HALT_WDOG   = 2'd3
    } halt_cause_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } mon_state_e;

endpackage

// File: rtl/mon_fifo.sv
// rtl/mon_fifo.sv - first-word-fall-through FIFO with full/empty and same-cycle push/pop
module mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells a full queue from an empty one when the indices match.
    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_q[AW-1:0]];

    // Next pointer values from the accepted push/pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pipe_trace_monitor.sv
// rtl/pipe_trace_monitor.sv - N-lane pipeline trace/halt monitor; PIPE_MON_FILTER_EN skips idle-cycle records
module pipe_trace_monitor
    import rv32i_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int XLEN        = 32,
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [LANES-1:0]                          lane_valid,
    input  logic [LANES*XLEN-1:0]                     lane_instr,
    input  logic [LANES*XLEN-1:0]                     lane_result,
    input  logic                                      stall,
    input  logic                                      branch_taken,
    input  logic [CNT_W-1:0]                          max_cycles,
    output logic                                      trace_valid,
    input  logic                                      trace_ready,
    output logic [CNT_W+2+LANES+2*LANES*XLEN-1:0]     trace_data,
    output logic [CNT_W-1:0]                          cycle_count,
    output logic [CNT_W-1:0]                          retired_count,
    output logic [CNT_W-1:0]                          stall_count,
    output logic [CNT_W-1:0]                          drop_count,
    output logic                                      halted,
    output logic [1:0]                                halt_cause,
    output logic [1:0]                                halt_lane,
    output logic                                      done
);

    localparam int REC_W = CNT_W + 2 + LANES + 2*LANES*XLEN;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             halted_q, halted_d;
    halt_cause_e      cause_q, cause_d;
    logic [1:0]       lane_q, lane_d;
    logic             done_q, done_d;

    logic             sys_hit;
    halt_cause_e      sys_cause;
    logic [1:0]       sys_lane;
    logic             wdog_hit;
    logic [CNT_W:0]   cycle_plus1;
    logic [CNT_W-1:0] lane_pop;
    logic             rec_en;
    logic             push;
    logic [REC_W-1:0] record;
    logic             fifo_full;
    logic             fifo_empty;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Lowest lane holding ECALL/EBREAK decides cause and lane; scan high to low so it wins.
    always_comb begin
        sys_hit   = 1'b0;
        sys_cause = HALT_NONE;
        sys_lane  = 2'd0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (lane_valid[k] && lane_instr[k*XLEN +: XLEN] == INSTR_ECALL) begin
                sys_hit   = 1'b1;
                sys_cause = HALT_ECALL;
                sys_lane  = 2'(k);
            end else if (lane_valid[k] && lane_instr[k*XLEN +: XLEN] == INSTR_EBREAK) begin
                sys_hit   = 1'b1;
                sys_cause = HALT_EBREAK;
                sys_lane  = 2'(k);
            end
        end
    end

    // Number of real instructions in execute this cycle.
    always_comb begin
        lane_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_pop = lane_pop + {{(CNT_W-1){1'b0}}, lane_valid[k]};
        end
    end

    // Watchdog compares the post-increment cycle count, widened so it cannot wrap.
    assign cycle_plus1 = {1'b0, cycle_q} + {{CNT_W{1'b0}}, 1'b1};
    assign wdog_hit    = (max_cycles != '0) && (cycle_plus1 >= {1'b0, max_cycles});

    assign record = {cycle_q, stall, branch_taken, lane_valid, lane_instr, lane_result};

`ifdef PIPE_MON_FILTER_EN
    // Idle cycles carry no information; the halting cycle is always kept.
    assign rec_en = sys_hit || wdog_hit || (lane_valid != '0) || stall;
`else
    assign rec_en = 1'b1;
`endif

    // Next-state logic: count and record while running, then wait for the trace to drain.
    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        retired_d   = retired_q;
        stall_cnt_d = stall_cnt_q;
        drop_d      = drop_q;
        halted_d    = halted_q;
        cause_d     = cause_q;
        lane_d      = lane_q;
        done_d      = done_q;
        push        = 1'b0;
        case (state_q)
            ST_RUN: begin
                cycle_d   = sat_add(cycle_q, CNT_ONE);
                retired_d = sat_add(retired_q, lane_pop);
                if (stall) begin
                    stall_cnt_d = sat_add(stall_cnt_q, CNT_ONE);
                end
                push = rec_en;
                if (push && fifo_full && !trace_ready) begin
                    drop_d = sat_add(drop_q, CNT_ONE);
                end
                if (sys_hit || wdog_hit) begin
                    halted_d = 1'b1;
                    cause_d  = sys_hit ? sys_cause : HALT_WDOG;
                    lane_d   = sys_hit ? sys_lane : 2'd0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cycle_q     <= '0;
            retired_q   <= '0;
            stall_cnt_q <= '0;
            drop_q      <= '0;
            halted_q    <= 1'b0;
            cause_q     <= HALT_NONE;
            lane_q      <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            retired_q   <= retired_d;
            stall_cnt_q <= stall_cnt_d;
            drop_q      <= drop_d;
            halted_q    <= halted_d;
            cause_q     <= cause_d;
            lane_q      <= lane_d;
            done_q      <= done_d;
        end
    end

    mon_fifo #(
        .WIDTH (REC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (record),
        .pop       (trace_ready),
        .pop_data  (trace_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign trace_valid   = !fifo_empty;
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;
    assign stall_count   = stall_cnt_q;
    assign drop_count    = drop_q;
    assign halted        = halted_q;
    assign halt_cause    = cause_q;
    assign halt_lane     = lane_q;
    assign done          = done_q;

endmodule
